// File: rtl/bch_chien_decoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : bch_chien_decoder
// Description : BCH(15,7) t=2 error-locator solve + Chien search + correction
//               over GF(16), x^4+x+1. Optional macro: BCH_CHIEN_EARLY_EXIT_EN
//               (no-error / uncorrectable words bypass the search).
// Revision    : 1.0 - initial release
// ============================================================================
module bch_chien_decoder #(
    parameter int CHECK_S2 = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [14:0] in_codeword,
    input  logic [3:0]  in_s1,
    input  logic [3:0]  in_s2,
    input  logic [3:0]  in_s3,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [14:0] out_codeword,
    output logic [1:0]  out_err_cnt,
    output logic        out_uncorr
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SOLVE  = 2'd1,
        ST_SEARCH = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [3:0] C_LAST_IDX = 4'd14;

    // ------------------------------------------------------------------
    // GF(16) helpers
    // ------------------------------------------------------------------
    function automatic logic [3:0] gf_exp(input logic [3:0] e);
        logic [3:0] r;
        case (e)
            4'd0:    r = 4'h1;
            4'd1:    r = 4'h2;
            4'd2:    r = 4'h4;
            4'd3:    r = 4'h8;
            4'd4:    r = 4'h3;
            4'd5:    r = 4'h6;
            4'd6:    r = 4'hC;
            4'd7:    r = 4'hB;
            4'd8:    r = 4'h5;
            4'd9:    r = 4'hA;
            4'd10:   r = 4'h7;
            4'd11:   r = 4'hE;
            4'd12:   r = 4'hF;
            4'd13:   r = 4'hD;
            4'd14:   r = 4'h9;
            default: r = 4'h1;
        endcase
        return r;
    endfunction

    // log(0) is undefined; callers guard zero operands
    function automatic logic [3:0] gf_log(input logic [3:0] a);
        logic [3:0] r;
        case (a)
            4'h1:    r = 4'd0;
            4'h2:    r = 4'd1;
            4'h3:    r = 4'd4;
            4'h4:    r = 4'd2;
            4'h5:    r = 4'd8;
            4'h6:    r = 4'd5;
            4'h7:    r = 4'd10;
            4'h8:    r = 4'd3;
            4'h9:    r = 4'd14;
            4'hA:    r = 4'd9;
            4'hB:    r = 4'd7;
            4'hC:    r = 4'd6;
            4'hD:    r = 4'd13;
            4'hE:    r = 4'd11;
            4'hF:    r = 4'd12;
            default: r = 4'd0;
        endcase
        return r;
    endfunction

    function automatic logic [3:0] gf_inv(input logic [3:0] a);
        logic [3:0] r;
        case (a)
            4'h1:    r = 4'h1;
            4'h2:    r = 4'h9;
            4'h3:    r = 4'hE;
            4'h4:    r = 4'hD;
            4'h5:    r = 4'hB;
            4'h6:    r = 4'h7;
            4'h7:    r = 4'h6;
            4'h8:    r = 4'hF;
            4'h9:    r = 4'h2;
            4'hA:    r = 4'hC;
            4'hB:    r = 4'h5;
            4'hC:    r = 4'hA;
            4'hD:    r = 4'h4;
            4'hE:    r = 4'h3;
            4'hF:    r = 4'h8;
            default: r = 4'h0;
        endcase
        return r;
    endfunction

    function automatic logic [3:0] mod15(input logic [4:0] v);
        logic [4:0] r;
        if (v >= 5'd30)      r = v - 5'd30;
        else if (v >= 5'd15) r = v - 5'd15;
        else                 r = v;
        return r[3:0];
    endfunction

    function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] r;
        if (a == 4'h0 || b == 4'h0) r = 4'h0;
        else r = gf_exp(mod15({1'b0, gf_log(a)} + {1'b0, gf_log(b)}));
        return r;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t      state_q,     state_d;
    logic [14:0] cw_q,        cw_d;
    logic [3:0]  s1_q,        s1_d;
    logic [3:0]  s2_q,        s2_d;
    logic [3:0]  s3_q,        s3_d;
    logic [3:0]  sig2_q,      sig2_d;
    logic        no_err_q,    no_err_d;
    logic        unc_q,       unc_d;
    logic [1:0]  deg_q,       deg_d;
    logic [3:0]  idx_q,       idx_d;
    logic [14:0] mask_q,      mask_d;
    logic [1:0]  cnt_q,       cnt_d;
    logic        out_valid_q, out_valid_d;
    logic [14:0] out_cw_q,    out_cw_d;
    logic [1:0]  out_cnt_q,   out_cnt_d;
    logic        out_unc_q,   out_unc_d;

    // ------------------------------------------------------------------
    // Solve: sigma1 = S1, sigma2 = S3/S1 + S1^2
    // ------------------------------------------------------------------
    logic [3:0] w_s1_sq;
    logic [3:0] w_sig2;
    logic       w_no_err;
    logic       w_uncorr;
    logic [1:0] w_deg;

    always_comb begin
        w_s1_sq  = gf_mul(s1_q, s1_q);
        w_sig2   = (s1_q == 4'h0) ? 4'h0 : (gf_mul(s3_q, gf_inv(s1_q)) ^ w_s1_sq);
        w_no_err = (s1_q == 4'h0) && (s3_q == 4'h0);
        w_uncorr = !w_no_err &&
                   (((s1_q == 4'h0) && (s3_q != 4'h0)) ||
                    ((CHECK_S2 != 0) && (s2_q != w_s1_sq)));
        w_deg    = (w_sig2 != 4'h0) ? 2'd2 : 2'd1;
    end

    // ------------------------------------------------------------------
    // Chien search: evaluate sigma(alpha^-idx)
    // ------------------------------------------------------------------
    logic [3:0]  w_term1;
    logic [3:0]  w_term2;
    logic        w_root;
    logic [14:0] w_mask_upd;
    logic [1:0]  w_cnt_upd;

    always_comb begin
        w_term1    = gf_mul(s1_q,   gf_exp(mod15(5'd15 - {1'b0, idx_q})));
        w_term2    = gf_mul(sig2_q, gf_exp(mod15(5'd30 - {idx_q, 1'b0})));
        w_root     = ((4'h1 ^ w_term1 ^ w_term2) == 4'h0);
        w_mask_upd = w_root ? (mask_q | (15'h1 << idx_q)) : mask_q;
        w_cnt_upd  = (w_root && cnt_q != 2'd3) ? cnt_q + 2'd1 : cnt_q;
    end

    // ------------------------------------------------------------------
    // Result selection; the mask is applied whole or not at all
    // ------------------------------------------------------------------
    logic        w_sel_no_err;
    logic        w_sel_unc;
    logic [14:0] w_res_cw;
    logic [1:0]  w_res_cnt;
    logic        w_res_unc;

    always_comb begin
        w_sel_no_err = (state_q == ST_SOLVE) ? w_no_err : no_err_q;
        w_sel_unc    = (state_q == ST_SOLVE) ? w_uncorr : unc_q;
        w_res_cw     = cw_q;
        w_res_cnt    = 2'd0;
        w_res_unc    = 1'b0;
        if (w_sel_no_err) begin
            w_res_unc = 1'b0;
        end else if (w_sel_unc || (w_cnt_upd != deg_q)) begin
            w_res_unc = 1'b1;
        end else begin
            w_res_cw  = cw_q ^ w_mask_upd;
            w_res_cnt = deg_q;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        cw_d        = cw_q;
        s1_d        = s1_q;
        s2_d        = s2_q;
        s3_d        = s3_q;
        sig2_d      = sig2_q;
        no_err_d    = no_err_q;
        unc_d       = unc_q;
        deg_d       = deg_q;
        idx_d       = idx_q;
        mask_d      = mask_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_cw_d    = out_cw_q;
        out_cnt_d   = out_cnt_q;
        out_unc_d   = out_unc_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    cw_d    = in_codeword;
                    s1_d    = in_s1;
                    s2_d    = in_s2;
                    s3_d    = in_s3;
                    state_d = ST_SOLVE;
                end
            end
            ST_SOLVE: begin
                sig2_d   = w_sig2;
                no_err_d = w_no_err;
                unc_d    = w_uncorr;
                deg_d    = w_deg;
                mask_d   = 15'h0;
                cnt_d    = 2'd0;
                idx_d    = 4'd0;
`ifdef BCH_CHIEN_EARLY_EXIT_EN
                if (w_no_err || w_uncorr) begin
                    out_valid_d = 1'b1;
                    out_cw_d    = w_res_cw;
                    out_cnt_d   = w_res_cnt;
                    out_unc_d   = w_res_unc;
                    state_d     = ST_DONE;
                end else begin
                    state_d = ST_SEARCH;
                end
`else
                state_d = ST_SEARCH;
`endif
            end
            ST_SEARCH: begin
                mask_d = w_mask_upd;
                cnt_d  = w_cnt_upd;
                idx_d  = idx_q + 4'd1;
                if (idx_q == C_LAST_IDX) begin
                    idx_d       = 4'd0;
                    out_valid_d = 1'b1;
                    out_cw_d    = w_res_cw;
                    out_cnt_d   = w_res_cnt;
                    out_unc_d   = w_res_unc;
                    state_d     = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cw_q        <= 15'h0;
            s1_q        <= 4'h0;
            s2_q        <= 4'h0;
            s3_q        <= 4'h0;
            sig2_q      <= 4'h0;
            no_err_q    <= 1'b0;
            unc_q       <= 1'b0;
            deg_q       <= 2'd0;
            idx_q       <= 4'd0;
            mask_q      <= 15'h0;
            cnt_q       <= 2'd0;
            out_valid_q <= 1'b0;
            out_cw_q    <= 15'h0;
            out_cnt_q   <= 2'd0;
            out_unc_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cw_q        <= cw_d;
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            s3_q        <= s3_d;
            sig2_q      <= sig2_d;
            no_err_q    <= no_err_d;
            unc_q       <= unc_d;
            deg_q       <= deg_d;
            idx_q       <= idx_d;
            mask_q      <= mask_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_cw_q    <= out_cw_d;
            out_cnt_q   <= out_cnt_d;
            out_unc_q   <= out_unc_d;
        end
    end

    assign in_ready     = (state_q == ST_IDLE);
    assign out_valid    = out_valid_q;
    assign out_codeword = out_cw_q;
    assign out_err_cnt  = out_cnt_q;
    assign out_uncorr   = out_unc_q;

endmodule
`default_nettype wire

// File: tb/tb_bch_chien_decoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_bch_chien_decoder
// Description : Directed self-checking bench for bch_chien_decoder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bch_chien_decoder;

    localparam int LAT_FULL = 16;
`ifdef BCH_CHIEN_EARLY_EXIT_EN
    localparam int LAT_SKIP = 1;
`else
    localparam int LAT_SKIP = 16;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [14:0] in_codeword;
    logic [3:0]  in_s1, in_s2, in_s3;
    logic        out_valid;
    logic        out_ready;
    logic [14:0] out_codeword;
    logic [1:0]  out_err_cnt;
    logic        out_uncorr;

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;

    int          lat, acc1, acc2;
    logic [14:0] ocw;
    logic [1:0]  ocnt;
    logic        ounc;

    bch_chien_decoder #(.CHECK_S2(1)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_codeword  (in_codeword),
        .in_s1        (in_s1),
        .in_s2        (in_s2),
        .in_s3        (in_s3),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_codeword (out_codeword),
        .out_err_cnt  (out_err_cnt),
        .out_uncorr   (out_uncorr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Drives one word (caller sits #1 after a rising edge, DUT idle), waits
    // for out_valid with a bound, and optionally completes the handshake.
    task automatic send_word(input logic [14:0] cw, input logic [3:0] s1,
                             input logic [3:0] s2, input logic [3:0] s3,
                             input bit ack, output int l, output int acc,
                             output logic [14:0] rcw, output logic [1:0] rcnt,
                             output logic runc);
        int n;
        in_codeword = cw;
        in_s1 = s1;
        in_s2 = s2;
        in_s3 = s3;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        acc = cyc;
        l = -1;
        n = 0;
        while (l < 0 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (out_valid) l = n;
        end
        rcw  = out_codeword;
        rcnt = out_err_cnt;
        runc = out_uncorr;
        if (ack && l > 0) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_codeword = 15'h0;
        in_s1 = 4'h0;
        in_s2 = 4'h0;
        in_s3 = 4'h0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset in_ready: got %b want 1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset out_valid: got %b want 0", out_valid); end
        total++; if (out_codeword !== 15'h0) begin bad++; $display("FAIL reset out_codeword: got %h want 0000", out_codeword); end
        total++; if (out_err_cnt !== 2'd0 || out_uncorr !== 1'b0) begin bad++; $display("FAIL reset cnt/uncorr: got %0d/%b want 0/0", out_err_cnt, out_uncorr); end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_no_error();
        send_word(15'h0000, 4'h0, 4'h0, 4'h0, 1'b1, lat, acc1, ocw, ocnt, ounc);
        total++; if (lat !== LAT_SKIP) begin bad++; $display("FAIL no_err latency: got %0d want %0d", lat, LAT_SKIP); end
        total++; if (ocw !== 15'h0000) begin bad++; $display("FAIL no_err codeword: got %h want 0000", ocw); end
        total++; if (ocnt !== 2'd0 || ounc !== 1'b0) begin bad++; $display("FAIL no_err cnt/uncorr: got %0d/%b want 0/0", ocnt, ounc); end
    endtask

    task automatic test_single();
        send_word(15'h0020, 4'h6, 4'h7, 4'h1, 1'b1, lat, acc1, ocw, ocnt, ounc);
        total++; if (lat !== LAT_FULL) begin bad++; $display("FAIL single latency: got %0d want %0d", lat, LAT_FULL); end
        total++; if (ocw !== 15'h0000) begin bad++; $display("FAIL single codeword: got %h want 0000", ocw); end
        total++; if (ocnt !== 2'd1 || ounc !== 1'b0) begin bad++; $display("FAIL single cnt/uncorr: got %0d/%b want 1/0", ocnt, ounc); end
    endtask

    task automatic test_double();
        send_word(15'h4001, 4'h8, 4'hC, 4'hE, 1'b1, lat, acc1, ocw, ocnt, ounc);
        total++; if (lat !== LAT_FULL) begin bad++; $display("FAIL double latency: got %0d want %0d", lat, LAT_FULL); end
        total++; if (ocw !== 15'h0000) begin bad++; $display("FAIL double codeword: got %h want 0000", ocw); end
        total++; if (ocnt !== 2'd2 || ounc !== 1'b0) begin bad++; $display("FAIL double cnt/uncorr: got %0d/%b want 2/0", ocnt, ounc); end
    endtask

    task automatic test_uncorr_s1zero();
        send_word(15'h1234, 4'h0, 4'h0, 4'h1, 1'b1, lat, acc1, ocw, ocnt, ounc);
        total++; if (lat !== LAT_SKIP) begin bad++; $display("FAIL s1zero latency: got %0d want %0d", lat, LAT_SKIP); end
        total++; if (ocw !== 15'h1234) begin bad++; $display("FAIL s1zero codeword: got %h want 1234", ocw); end
        total++; if (ocnt !== 2'd0 || ounc !== 1'b1) begin bad++; $display("FAIL s1zero cnt/uncorr: got %0d/%b want 0/1", ocnt, ounc); end
    endtask

    task automatic test_uncorr_s2();
        send_word(15'h0F0F, 4'h2, 4'h2, 4'h0, 1'b1, lat, acc1, ocw, ocnt, ounc);
        total++; if (lat !== LAT_SKIP) begin bad++; $display("FAIL s2check latency: got %0d want %0d", lat, LAT_SKIP); end
        total++; if (ocw !== 15'h0F0F) begin bad++; $display("FAIL s2check codeword: got %h want 0f0f", ocw); end
        total++; if (ocnt !== 2'd0 || ounc !== 1'b1) begin bad++; $display("FAIL s2check cnt/uncorr: got %0d/%b want 0/1", ocnt, ounc); end
    endtask

    // sigma(x) = 1 + x + alpha^3 x^2 has no roots in GF(16) (trace of alpha^3 is 1)
    task automatic test_no_roots();
        send_word(15'h0ABC, 4'h1, 4'h1, 4'h9, 1'b1, lat, acc1, ocw, ocnt, ounc);
        total++; if (lat !== LAT_FULL) begin bad++; $display("FAIL noroot latency: got %0d want %0d", lat, LAT_FULL); end
        total++; if (ocw !== 15'h0ABC) begin bad++; $display("FAIL noroot codeword: got %h want 0abc", ocw); end
        total++; if (ocnt !== 2'd0 || ounc !== 1'b1) begin bad++; $display("FAIL noroot cnt/uncorr: got %0d/%b want 0/1", ocnt, ounc); end
    endtask

    task automatic test_stall();
        out_ready = 1'b0;
        send_word(15'h0020, 4'h6, 4'h7, 4'h1, 1'b0, lat, acc1, ocw, ocnt, ounc);
        total++; if (lat !== LAT_FULL) begin bad++; $display("FAIL stall latency: got %0d want %0d", lat, LAT_FULL); end
        in_valid = 1'b1;
        in_codeword = 15'h7FFF;
        in_s1 = 4'h0;
        in_s2 = 4'h0;
        in_s3 = 4'h0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            total++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_codeword !== 15'h0000 ||
                out_err_cnt !== 2'd1 || out_uncorr !== 1'b0) begin
                bad++;
                $display("FAIL stall hold cycle %0d: got v=%b rdy=%b cw=%h cnt=%0d unc=%b want v=1 rdy=0 cw=0000 cnt=1 unc=0",
                         i, out_valid, in_ready, out_codeword, out_err_cnt, out_uncorr);
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL stall release: got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        send_word(15'h4001, 4'h8, 4'hC, 4'hE, 1'b1, lat, acc1, ocw, ocnt, ounc);
        total++; if (ocw !== 15'h0000 || ocnt !== 2'd2) begin bad++; $display("FAIL b2b first: got cw=%h cnt=%0d want cw=0000 cnt=2", ocw, ocnt); end
        send_word(15'h0421, 4'h1, 4'h1, 4'h0, 1'b1, lat, acc2, ocw, ocnt, ounc);
        total++; if (acc2 - acc1 !== 18) begin bad++; $display("FAIL b2b spacing: got %0d want 18", acc2 - acc1); end
        total++; if (ocw !== 15'h0001) begin bad++; $display("FAIL b2b second codeword: got %h want 0001", ocw); end
        total++; if (ocnt !== 2'd2 || ounc !== 1'b0) begin bad++; $display("FAIL b2b second cnt/uncorr: got %0d/%b want 2/0", ocnt, ounc); end
    endtask

    task automatic test_reset_midsearch();
        int n;
        bit stray;
        out_ready = 1'b1;
        in_codeword = 15'h4001;
        in_s1 = 4'h8;
        in_s2 = 4'hC;
        in_s3 = 4'hE;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL midreset handshake: got rdy=%b v=%b want rdy=1 v=0", in_ready, out_valid); end
        total++; if (out_codeword !== 15'h0 || out_err_cnt !== 2'd0 || out_uncorr !== 1'b0) begin bad++; $display("FAIL midreset outputs: got cw=%h cnt=%0d unc=%b want 0/0/0", out_codeword, out_err_cnt, out_uncorr); end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        stray = 1'b0;
        for (n = 0; n < 20; n++) begin
            @(posedge clk);
            #1;
            if (out_valid) stray = 1'b1;
        end
        total++; if (stray !== 1'b0) begin bad++; $display("FAIL midreset stray out_valid: got 1 want 0"); end
        send_word(15'h0020, 4'h6, 4'h7, 4'h1, 1'b1, lat, acc1, ocw, ocnt, ounc);
        total++; if (lat !== LAT_FULL) begin bad++; $display("FAIL midreset fresh latency: got %0d want %0d", lat, LAT_FULL); end
        total++; if (ocw !== 15'h0000 || ocnt !== 2'd1 || ounc !== 1'b0) begin bad++; $display("FAIL midreset fresh result: got cw=%h cnt=%0d unc=%b want 0000/1/0", ocw, ocnt, ounc); end
    endtask

    initial begin
        test_reset();
        test_no_error();
        test_single();
        test_double();
        test_uncorr_s1zero();
        test_uncorr_s2();
        test_no_roots();
        test_stall();
        test_back_to_back();
        test_reset_midsearch();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
